sw_debounce: RTL and testbench
==============================

# sw_debounce

Input conditioner for the board slide switches and push keys. It sits directly upstream of the SoC's `sw_export` input. Each raw pin is synchronised into `clk` and debounced against a shared millisecond tick. Only clean, stable levels are presented to the PIO, along with per-bit change strobes and a change-event counter for software polling.

## Interface

Parameters:
- `WIDTH`, default 32: number of switch/key bits; matches `sw_export` width.
- `TICK_DIV`, default 50000: `clk` cycles per debounce tick (1 ms at 50 MHz). Minimum 2.
- `STABLE_TICKS`, default 10: consecutive ticks a new level must persist before acceptance. Minimum 1.

Ports:
- `clk`, in, 1: single clock for all logic.
- `rst`, in, 1: reset; synchronous and active-high.
- `sw_raw`, in, WIDTH: asynchronous board pins.
- `evt_clr`, in, 1: clears `evt_count`.
- `sw_stable`, out, WIDTH: debounced level; connects to `sw_export`.
- `sw_changed`, out, WIDTH: one-cycle strobe per bit whose `sw_stable` just toggled.
- `any_changed`, out, 1: OR of `sw_changed`.
- `evt_count`, out, 16: number of cycles in which `any_changed` was asserted; wraps at 16 bits.

## Operation

- **Synchroniser.** Two-flop chain per bit: `sync1 <= sw_raw`, `sync2 <= sync1`. Only `sync2` is used downstream.
- **Prescaler.**
  - Counter `pre` runs 0..TICK_DIV-1 and wraps to 0.
  - `tick` is combinational and high while `pre == TICK_DIV-1`, i.e. one cycle in every TICK_DIV.
- **Per-bit debounce.** Each bit has a counter `cnt[i]` of width clog2(STABLE_TICKS+1). Priority per bit, in order:
  - **Match:** `sync2[i] == sw_stable[i]` → `cnt[i] <= 0`. Any glitch shorter than acceptance restarts the count.
  - **Accept:** mismatch, `tick`, and `cnt[i] == STABLE_TICKS-1` → `sw_stable[i] <= sync2[i]`, `cnt[i] <= 0`, `sw_changed[i] <= 1`.
  - **Count:** mismatch and `tick` → `cnt[i] <= cnt[i] + 1`.
  - **Hold:** otherwise `cnt[i]` holds.
  - `sw_changed[i]` is 0 in every cycle with no accept.
- **Event counter.**
  - `evt_clr` with `any_changed` in the same cycle → `evt_count <= 1`.
  - `evt_clr` alone → 0.
  - `any_changed` alone → +1, modulo 2^16.
  - Several bits changing in one cycle count as one event.
- **Reset** (`rst` high at a `clk` edge):
  - `sync1`, `sync2`, `pre`, all `cnt`, `sw_stable`, `sw_changed`, `evt_count` <= 0.
  - Reset mid-debounce discards partial counts.
  - A pin held high through reset is accepted as a normal change after reset: strobe and count included, no suppression.

## Timing

- All outputs are registered except `any_changed`, which is combinational OR of registered `sw_changed`.
- `sw_stable` and `sw_changed` update on the same edge. `evt_count` reflects an event on the following edge.
- Synchroniser latency: a `sw_raw` edge is visible on `sync2` 2 cycles later.
- Acceptance latency after `sync2` changes and then holds: min (STABLE_TICKS-1)·TICK_DIV+1 cycles, max STABLE_TICKS·TICK_DIV cycles. Exact value depends on the `pre` phase.
- A pulse on `sync2` spanning fewer than STABLE_TICKS tick edges is never accepted.
- Back-to-back changes on one bit need at least STABLE_TICKS ticks between acceptances.
- `sw_changed` is never high for 2 consecutive cycles on the same bit, because a tick is at most 1 in TICK_DIV ≥ 2 cycles.

## Test plan

Bench uses WIDTH=4, TICK_DIV=4, STABLE_TICKS=3.

- **Reset values:** hold `rst` 3 cycles with `sw_raw=4'hF` → `sw_stable=0`, `evt_count=0`, `sw_changed=0` throughout. After release, `sw_stable` becomes `4'hF` within 2+12 cycles, with exactly one `sw_changed=4'hF` strobe and `evt_count=1`.
- **Clean edge:** `sw_raw[0]` 0→1 held → `sw_stable[0]` rises between cycle 2+9 and 2+12 after the edge, `sw_changed=4'h1` for one cycle, `evt_count` +1.
- **Glitch rejection:** `sw_raw[1]` high for 6 cycles then low → `sw_stable` unchanged, no strobe, `evt_count` unchanged. Repeat with 7-cycle glitches every 8 cycles for 200 cycles → still no acceptance.
- **Simultaneous change:** bits 2 and 3 toggle on the same cycle → single cycle with `sw_changed=4'hC`, `evt_count` +1 (not +2).
- **Clear collision:** assert `evt_clr` on the exact cycle `any_changed=1` → `evt_count=1` next cycle. `evt_clr` alone → 0.
- **Wrap:** preload via 65535 events (or force) then one more change → `evt_count=0`. Also apply mid-debounce `rst` with `cnt=2` → no acceptance until a full 3 ticks elapse after reset.

Source files
------------

// File: rtl/sw_debounce.sv
// sw_debounce: conditions raw board switch/key pins for the SoC PIO.
// Each pin is synchronised into clk with a two-flop chain, then debounced
// against a shared prescaled tick. A new level is accepted only after it
// has persisted, without interruption, across STABLE_TICKS tick edges.
//
// Ports:
//   clk          single clock for all logic
//   rst          synchronous, active-high reset
//   sw_raw       asynchronous board pins
//   evt_clr      clears evt_count (an event in the same cycle still counts)
//   sw_stable    debounced level, feeds sw_export
//   sw_changed   one-cycle strobe per bit whose sw_stable just toggled
//   any_changed  OR of sw_changed (combinational from registered strobes)
//   evt_count    number of cycles with any_changed high, wraps at 16 bits
module sw_debounce #(
  parameter int WIDTH        = 32,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             evt_clr,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_changed,
  output logic [15:0]      evt_count
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]            sync1_r;
  logic [WIDTH-1:0]            sync2_r;
  logic [WIDTH-1:0]            stable_r;
  logic [WIDTH-1:0]            changed_r;
  logic [PRE_W-1:0]            pre_r;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_r;
  logic [15:0]                 evt_count_r;
  logic                        tick_s;
  logic                        any_changed_s;

  // Two-flop synchroniser; only sync2_r is used by the debounce logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= sw_raw;
      sync2_r <= sync1_r;
    end
  end

  // Prescaler counting 0..TICK_DIV-1; the last count is the tick cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r <= {PRE_W{1'b0}};
    end else if (tick_s) begin
      pre_r <= {PRE_W{1'b0}};
    end else begin
      pre_r <= pre_r + PRE_W'(1'b1);
    end
  end

  // Tick decode and change summary.
  always_comb begin
    tick_s        = (pre_r == PRE_LAST);
    any_changed_s = |changed_r;
  end

  // Per-bit debounce: a matching cycle restarts the count, so any glitch
  // shorter than the acceptance window is discarded. Accept is checked
  // before count so a bit never counts past STABLE_TICKS-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_r  <= {WIDTH{1'b0}};
      changed_r <= {WIDTH{1'b0}};
      cnt_r     <= {(WIDTH*CNT_W){1'b0}};
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          cnt_r[i]     <= {CNT_W{1'b0}};
          changed_r[i] <= 1'b0;
        end else if (tick_s && (cnt_r[i] == CNT_LAST)) begin
          stable_r[i]  <= sync2_r[i];
          cnt_r[i]     <= {CNT_W{1'b0}};
          changed_r[i] <= 1'b1;
        end else if (tick_s) begin
          cnt_r[i]     <= cnt_r[i] + CNT_W'(1'b1);
          changed_r[i] <= 1'b0;
        end else begin
          cnt_r[i]     <= cnt_r[i];
          changed_r[i] <= 1'b0;
        end
      end
    end
  end

  // Event counter: one count per cycle with any change, however many bits
  // toggled. A clear colliding with an event leaves that event counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_count_r <= 16'h0000;
    end else begin
      case ({evt_clr, any_changed_s})
        2'b11:   evt_count_r <= 16'h0001;
        2'b10:   evt_count_r <= 16'h0000;
        2'b01:   evt_count_r <= evt_count_r + 16'h0001;
        default: evt_count_r <= evt_count_r;
      endcase
    end
  end

  assign sw_stable   = stable_r;
  assign sw_changed  = changed_r;
  assign any_changed = any_changed_s;
  assign evt_count   = evt_count_r;

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

  logic        clk;
  logic        rst;
  logic [3:0]  sw_raw;
  logic        evt_clr;
  logic [3:0]  sw_stable;
  logic [3:0]  sw_changed;
  logic        any_changed;
  logic [15:0] evt_count;

  int n_vec;
  int n_err;

  // Reference model state (pre-edge values between steps).
  logic [3:0]  m_sync1, m_sync2, m_stable, m_changed;
  logic [15:0] m_evt;
  int          n_edge;       // non-reset edges since the last reset edge
  int          run_start[4]; // edge index where the current mismatch run began
  bit          run_act[4];

  sw_debounce #(.WIDTH(4), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_raw      (sw_raw),
    .evt_clr     (evt_clr),
    .sw_stable   (sw_stable),
    .sw_changed  (sw_changed),
    .any_changed (any_changed),
    .evt_count   (evt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle, advance the model for that edge, then compare all outputs.
  task automatic step(input logic [3:0] raw, input logic clr, input logic r);
    logic [3:0] nchg;
    logic       anyp;
    int         ticks;
    sw_raw  = raw;
    evt_clr = clr;
    rst     = r;
    @(posedge clk);
    if (r) begin
      m_sync1 = 4'h0; m_sync2 = 4'h0; m_stable = 4'h0; m_changed = 4'h0;
      m_evt = 16'h0000; n_edge = 0;
      for (int i = 0; i < 4; i++) run_act[i] = 1'b0;
    end else begin
      anyp = |m_changed;
      nchg = 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (m_sync2[i] == m_stable[i]) begin
          run_act[i] = 1'b0;
        end else begin
          if (!run_act[i]) begin
            run_act[i]   = 1'b1;
            run_start[i] = n_edge;
          end
          // ticks are edges k with k%4==3; count those in [run_start, n_edge]
          ticks = (n_edge + 1) / 4 - run_start[i] / 4;
          if ((n_edge % 4 == 3) && ticks == 3) begin
            m_stable[i] = m_sync2[i];
            nchg[i]     = 1'b1;
            run_act[i]  = 1'b0;
          end
        end
      end
      if (clr && anyp) m_evt = 16'h0001;
      else if (clr)    m_evt = 16'h0000;
      else if (anyp)   m_evt = m_evt + 16'h0001;
      m_changed = nchg;
      m_sync2   = m_sync1;
      m_sync1   = raw;
      n_edge++;
    end
    #1;
    n_vec++;
    assert ({sw_stable, sw_changed, any_changed, evt_count} ===
            {m_stable, m_changed, |m_changed, m_evt})
    else begin
      n_err++;
      $error("FAIL step edge=%0d: observed stable=%h chg=%h any=%b evt=%h expected stable=%h chg=%h any=%b evt=%h",
             n_edge, sw_stable, sw_changed, any_changed, evt_count,
             m_stable, m_changed, |m_changed, m_evt);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0]  raw;
    logic [15:0] evt_snap;
    int          strobes;
    bit          pend;
    bit          done;
    n_vec = 0; n_err = 0;
    rst = 1'b1; sw_raw = 4'hF; evt_clr = 1'b0;

    // Reset with pins high: outputs stay clear.
    for (int k = 0; k < 3; k++) step(4'hF, 1'b0, 1'b1);
    check("reset_stable", {28'h0, sw_stable}, 32'h0);
    check("reset_evt", {16'h0, evt_count}, 32'h0);

    // Pins held through reset are accepted as a normal change.
    strobes = 0;
    for (int k = 0; k < 14; k++) begin
      step(4'hF, 1'b0, 1'b0);
      if (sw_changed == 4'hF) strobes++;
    end
    check("post_reset_stable", {28'h0, sw_stable}, 32'hF);
    check("post_reset_strobes", strobes, 32'd1);
    check("post_reset_evt", {16'h0, evt_count}, 32'h1);

    // Clean edge on bit 0: fall, then rise.
    for (int k = 0; k < 20; k++) step(4'hE, 1'b0, 1'b0);
    check("bit0_low", {28'h0, sw_stable}, 32'hE);
    evt_snap = m_evt;
    strobes = 0;
    for (int k = 0; k < 20; k++) begin
      step(4'hF, 1'b0, 1'b0);
      if (sw_changed == 4'h1) strobes++;
    end
    check("bit0_high", {28'h0, sw_stable}, 32'hF);
    check("bit0_strobes", strobes, 32'd1);
    check("bit0_evt", {16'h0, evt_count}, {16'h0, evt_snap + 16'h0001});

    // Glitch rejection on bit 1.
    evt_snap = m_evt;
    for (int k = 0; k < 6; k++) step(4'hD, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(4'hF, 1'b0, 1'b0);
    check("glitch6_stable", {28'h0, sw_stable}, 32'hF);
    check("glitch6_evt", {16'h0, evt_count}, {16'h0, evt_snap});
    for (int g = 0; g < 25; g++) begin
      for (int k = 0; k < 7; k++) step(4'hD, 1'b0, 1'b0);
      step(4'hF, 1'b0, 1'b0);
    end
    for (int k = 0; k < 6; k++) step(4'hF, 1'b0, 1'b0);
    check("glitch7_stable", {28'h0, sw_stable}, 32'hF);
    check("glitch7_evt", {16'h0, evt_count}, {16'h0, evt_snap});

    // Simultaneous change of bits 2 and 3 counts once.
    evt_snap = m_evt;
    strobes = 0;
    for (int k = 0; k < 20; k++) begin
      step(4'h3, 1'b0, 1'b0);
      if (sw_changed == 4'hC) strobes++;
    end
    check("simul_strobes", strobes, 32'd1);
    check("simul_evt", {16'h0, evt_count}, {16'h0, evt_snap + 16'h0001});

    // Clear colliding with an event, then a lone clear.
    pend = 1'b0; done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (pend) begin
        step(4'h2, 1'b1, 1'b0);
        check("clr_collide", {16'h0, evt_count}, 32'h1);
        pend = 1'b0; done = 1'b1;
      end else begin
        step(4'h2, 1'b0, 1'b0);
        if (!done && m_changed != 4'h0) pend = 1'b1;
      end
    end
    check("clr_collide_seen", {31'h0, done}, 32'h1);
    step(4'h2, 1'b1, 1'b0);
    check("clr_alone", {16'h0, evt_count}, 32'h0);

    // Wrap: preload the counter to all ones, then one more event.
    @(negedge clk);
    force dut.evt_count_r = 16'hFFFF;
    #1;
    release dut.evt_count_r;
    m_evt = 16'hFFFF;
    for (int k = 0; k < 20; k++) step(4'h3, 1'b0, 1'b0);
    check("wrap_evt", {16'h0, evt_count}, 32'h0);

    // Reset mid-debounce after two ticks of bit 3: partial count is lost.
    for (int k = 0; k < 20 && !(run_act[3] && (n_edge / 4 - run_start[3] / 4) == 2); k++)
      step(4'hB, 1'b0, 1'b0);
    check("mid_pre_reset_bit3", {31'h0, sw_stable[3]}, 32'h0);
    step(4'hB, 1'b0, 1'b1);
    for (int k = 0; k < 11; k++) step(4'hB, 1'b0, 1'b0);
    check("mid_no_early_accept", {28'h0, sw_stable}, 32'h0);
    for (int k = 0; k < 4; k++) step(4'hB, 1'b0, 1'b0);
    check("mid_accept", {28'h0, sw_stable}, 32'hB);

    // Randomised traffic against the model.
    raw = 4'hB;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) raw = 4'($urandom_range(0, 15));
      step(raw, ($urandom_range(0, 31) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
